// File: rtl/rlbp_code_reader.sv
// Return-path reader for the pixel comparator: synchronises and majority-filters CMP,
// assembles NBITS decisions per frame into an RLBP code and queues codes in a FWFT FIFO.
module rlbp_code_reader #(
  parameter int NBITS       = 12,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                                wb_clk_i,
  input  logic                                wb_rst_ni,
  input  logic                                cmp_i,
  input  logic                                frame_start_i,
  input  logic                                sample_i,
  input  logic                                clr_flags_i,
  output logic [NBITS-1:0]                    code_o,
  output logic                                code_valid_o,
  input  logic                                code_ready_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     level_o,
  output logic                                busy_o,
  output logic                                overflow_o,
  output logic                                frame_err_o
);

  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(NBITS + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, PUSH} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [2:0]             hist_q;
  logic                   cmp_s;
  logic                   filt_bit;
  logic [CNT_W-1:0]       cnt_q;
  logic [NBITS-1:0]       acc_q;
  logic                   clear_acc;
  logic                   take_bit;
  logic                   set_ferr;

  logic [NBITS-1:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q;
  logic [PTR_W-1:0]       rd_ptr_q;
  logic [LVL_W-1:0]       level_q;
  logic                   fifo_full;
  logic                   pop;
  logic                   push;
  logic                   drop;
  logic                   overflow_q;
  logic                   frame_err_q;

  assign cmp_s    = sync_q[SYNC_STAGES-1];
  assign filt_bit = (hist_q[2] & hist_q[1]) | (hist_q[2] & hist_q[0]) | (hist_q[1] & hist_q[0]);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], cmp_i};
      hist_q <= {hist_q[1:0], cmp_s};
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // A frame start while collecting restarts the code; in PUSH it simply chains into the next frame.
  always_comb begin
    state_d   = state_q;
    clear_acc = 1'b0;
    take_bit  = 1'b0;
    set_ferr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_start_i) begin
          state_d   = COLLECT;
          clear_acc = 1'b1;
        end
      end
      COLLECT: begin
        if (frame_start_i) begin
          clear_acc = 1'b1;
          set_ferr  = 1'b1;
        end else if (sample_i) begin
          take_bit = 1'b1;
          if (cnt_q == CNT_W'(NBITS - 1)) state_d = PUSH;
        end
      end
      PUSH: begin
        if (frame_start_i) begin
          state_d   = COLLECT;
          clear_acc = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bits enter at the MSB so the first sample ends up in bit 0 after NBITS shifts.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else if (clear_acc) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else if (take_bit) begin
      cnt_q <= cnt_q + CNT_W'(1);
      acc_q <= {filt_bit, acc_q[NBITS-1:1]};
    end
  end

  assign fifo_full = (level_q == LVL_W'(FIFO_DEPTH));
  assign pop       = code_valid_o & code_ready_i;
  assign push      = (state_q == PUSH) & (~fifo_full | pop);
  assign drop      = (state_q == PUSH) & fifo_full & ~pop;

  always_ff @(posedge wb_clk_i) begin
    if (push) mem_q[wr_ptr_q] <= acc_q;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Setting a flag wins over a same-cycle clear.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (drop)             overflow_q <= 1'b1;
      else if (clr_flags_i) overflow_q <= 1'b0;
      if (set_ferr)         frame_err_q <= 1'b1;
      else if (clr_flags_i) frame_err_q <= 1'b0;
    end
  end

  assign code_valid_o = (level_q != '0);
  assign code_o       = code_valid_o ? mem_q[rd_ptr_q] : '0;
  assign level_o      = level_q;
  assign busy_o       = (state_q != IDLE);
  assign overflow_o   = overflow_q;
  assign frame_err_o  = frame_err_q;

endmodule
